msrv32_su: RTL and testbench
============================

# msrv32_su

Store unit for the msrv32 core: the write-side counterpart of the load unit. Takes a store request from the pipeline (effective address, rs2 data, size), performs byte-lane replication and write-strobe generation, detects misalignment, and runs a single AHB-Lite write transfer through address and data phases. It stalls the pipeline until the transfer completes, then reports completion or a bus error.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk_in  input  1  core clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- st_req_in  input  1  store request, level; sampled only in IDLE.
- st_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- iadder_in  input  32  effective byte address.
- rs2_in  input  32  store data; right-justified.
- ahb_ready_in  input  1  HREADY.
- ahb_resp_in  input  1  HRESP; 1 = error.
- haddr_out  output  32  word-aligned address {iadder[31:2], 2'b00}.
- htrans_out  output  2  00 IDLE, 10 NONSEQ.
- hwrite_out  output  1  write indicator.
- hsize_out  output  3  000 byte, 001 half, 010 word.
- hwdata_out  output  32  lane-replicated write data.
- wr_mask_out  output  4  byte strobes, bit i = byte lane i.
- stall_out  output  1  pipeline hold.
- done_out  output  1  one-cycle completion pulse.
- err_out  output  1  one-cycle bus-error pulse, coincident with done_out.
- misaligned_out  output  1  one-cycle misaligned-store pulse.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if st_req_in=1, the block registers address, size, lane data, and mask. Misaligned requests do not start a transfer.
  - Aligned request: go to ADDR.
  - Misaligned request (half with iadder[0]=1, or word with iadder[1:0]!=0): stay in IDLE, pulse misaligned_out for 1 cycle, capture nothing, start no transfer.
- ADDR: htrans_out=10, hwrite_out=1, haddr_out/hsize_out valid.
  - ahb_ready_in=1: go to DATA.
  - ahb_ready_in=0: hold every output unchanged.
- DATA: htrans_out=00, hwrite_out=0, hwdata_out/wr_mask_out valid and stable.
  - ahb_ready_in=1: go to IDLE and pulse done_out next cycle. err_out pulses next cycle if ahb_resp_in=1 at that edge.
  - ahb_ready_in=0: hold.
- stall_out=1 whenever state != IDLE, and also in the cycle an aligned request is accepted. This is the only combinational term: st_req_in & aligned & IDLE.
- Lane formatting, a = iadder[1:0]:
  - byte: hwdata = {4{rs2[7:0]}}, mask = 4'b0001 << a.
  - half: hwdata = {2{rs2[15:0]}}, mask = a[1] ? 1100 : 0011.
  - word: hwdata = rs2, mask = 1111.
- hwdata_out and wr_mask_out are 0 outside DATA. haddr_out is 0 in IDLE.
- Single transfers only; no back-to-back overlap. A new request is sampled only after returning to IDLE.

## Timing
- Reset values: every output is 0; htrans_out=00; state=IDLE.
- Reset asserted mid-transfer: immediate return to IDLE, all outputs 0, no done_out or err_out pulse.
- Minimum latency, request accepted at edge 0 with ready held high:
  - ADDR during cycle 1.
  - DATA during cycle 2.
  - IDLE plus done_out=1 during cycle 3.
  - stall_out high in cycles 0-2.
- Each low cycle of ahb_ready_in in ADDR or DATA adds exactly one cycle.
- misaligned_out is asserted the cycle after the request edge. stall_out stays 0 for misaligned requests.
- st_req_in is ignored while not in IDLE. The pipeline holds it, and it is re-sampled in IDLE only after done_out. The requester must deassert it on done_out.
- ahb_resp_in is ignored outside DATA and when ahb_ready_in=0.

## Test plan
- Byte store, iadder=0x1003, rs2=0x000000A5, ready=1.
  - ADDR: haddr=0x1000, hsize=000.
  - DATA: hwdata=0xA5A5A5A5, mask=1000.
  - done_out in cycle 3.
- Half store, iadder=0x2002, rs2=0x1234BEEF, ready low 2 cycles in ADDR.
  - ADDR outputs held 3 cycles.
  - DATA: hwdata=0xBEEFBEEF, mask=1100.
  - done_out in cycle 5.
- Word store, iadder=0x3001: misaligned_out=1 one cycle, htrans stays 00, stall_out=0. Repeat with iadder=0x3000 → normal transfer, mask=1111.
- Word store with ahb_resp_in=1 and ready=1 in DATA → done_out=1 and err_out=1 in the same cycle, both 0 the next cycle.
- Assert rst_in during DATA with ready=0 → all outputs 0 immediately, no done_out pulse, next request accepted normally.
- st_req_in held high through a transfer → exactly one transfer per IDLE visit. A second transfer starts only after done_out.

Source files
------------

// File: rtl/msrv32_su.sv
// Store unit: formats store data into byte lanes, detects misalignment and
// runs a single AHB-Lite write transfer (address phase, then data phase).
module msrv32_su (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        st_req_in,
  input  logic [1:0]  st_size_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  output logic [3:0]  wr_mask_out,
  output logic        stall_out,
  output logic        done_out,
  output logic        err_out,
  output logic        misaligned_out
);

  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t        state, state_d;
  logic [DW-1:0] data_r, data_d;
  logic [MW-1:0] mask_r, mask_d;
  logic [DW-1:0] haddr_d, hwdata_d;
  logic [1:0]    htrans_d;
  logic          hwrite_d;
  logic [2:0]    hsize_d;
  logic [MW-1:0] wr_mask_d;
  logic          done_d, err_d, mis_d;

  logic          is_half, is_word, misaligned;
  logic [DW-1:0] lane_data;
  logic [MW-1:0] lane_mask;
  logic [2:0]    req_hsize;

  // Lane replication, strobes and alignment check for the incoming request
  always_comb begin
    is_half    = (st_size_in == 2'b01);
    is_word    = st_size_in[1];
    misaligned = (is_half & iadder_in[0]) | (is_word & (|iadder_in[1:0]));
    if (is_word) begin
      lane_data = rs2_in;
      lane_mask = 4'b1111;
      req_hsize = 3'b010;
    end else if (is_half) begin
      lane_data = {2{rs2_in[15:0]}};
      lane_mask = iadder_in[1] ? 4'b1100 : 4'b0011;
      req_hsize = 3'b001;
    end else begin
      lane_data = {4{rs2_in[7:0]}};
      lane_mask = MW'(4'b0001 << iadder_in[1:0]);
      req_hsize = 3'b000;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d   = state;
    data_d    = data_r;
    mask_d    = mask_r;
    haddr_d   = haddr_out;
    htrans_d  = htrans_out;
    hwrite_d  = hwrite_out;
    hsize_d   = hsize_out;
    hwdata_d  = hwdata_out;
    wr_mask_d = wr_mask_out;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mis_d     = 1'b0;
    case (state)
      S_IDLE: begin
        if (st_req_in) begin
          if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            state_d  = S_ADDR;
            data_d   = lane_data;
            mask_d   = lane_mask;
            haddr_d  = {iadder_in[31:2], 2'b00};
            htrans_d = 2'b10;
            hwrite_d = 1'b1;
            hsize_d  = req_hsize;
          end
        end
      end
      S_ADDR: begin
        if (ahb_ready_in) begin
          state_d   = S_DATA;
          htrans_d  = 2'b00;
          hwrite_d  = 1'b0;
          hwdata_d  = data_r;
          wr_mask_d = mask_r;
        end
      end
      S_DATA: begin
        if (ahb_ready_in) begin
          state_d   = S_IDLE;
          haddr_d   = '0;
          hsize_d   = '0;
          hwdata_d  = '0;
          wr_mask_d = '0;
          done_d    = 1'b1;
          err_d     = ahb_resp_in;
        end
      end
      default: begin
        state_d   = S_IDLE;
        haddr_d   = '0;
        htrans_d  = '0;
        hwrite_d  = 1'b0;
        hsize_d   = '0;
        hwdata_d  = '0;
        wr_mask_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      data_r         <= '0;
      mask_r         <= '0;
      haddr_out      <= '0;
      htrans_out     <= '0;
      hwrite_out     <= 1'b0;
      hsize_out      <= '0;
      hwdata_out     <= '0;
      wr_mask_out    <= '0;
      done_out       <= 1'b0;
      err_out        <= 1'b0;
      misaligned_out <= 1'b0;
    end else begin
      state          <= state_d;
      data_r         <= data_d;
      mask_r         <= mask_d;
      haddr_out      <= haddr_d;
      htrans_out     <= htrans_d;
      hwrite_out     <= hwrite_d;
      hsize_out      <= hsize_d;
      hwdata_out     <= hwdata_d;
      wr_mask_out    <= wr_mask_d;
      done_out       <= done_d;
      err_out        <= err_d;
      misaligned_out <= mis_d;
    end
  end

  // Stall also covers the accepting cycle so the pipeline freezes in time
  assign stall_out = ~rst_in & ((state != S_IDLE) |
                                (st_req_in & ~misaligned));

endmodule

// File: tb/tb_msrv32_su.sv
// Directed testbench for msrv32_su with hand-computed expected values.
module tb_msrv32_su;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        st_req_in;
  logic [1:0]  st_size_in;
  logic [31:0] iadder_in;
  logic [31:0] rs2_in;
  logic        ahb_ready_in;
  logic        ahb_resp_in;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [31:0] hwdata_out;
  logic [3:0]  wr_mask_out;
  logic        stall_out;
  logic        done_out;
  logic        err_out;
  logic        misaligned_out;

  int total  = 0;
  int passed = 0;

  msrv32_su dut (
    .clk_in(clk_in), .rst_in(rst_in), .st_req_in(st_req_in),
    .st_size_in(st_size_in), .iadder_in(iadder_in), .rs2_in(rs2_in),
    .ahb_ready_in(ahb_ready_in), .ahb_resp_in(ahb_resp_in),
    .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
    .hsize_out(hsize_out), .hwdata_out(hwdata_out), .wr_mask_out(wr_mask_out),
    .stall_out(stall_out), .done_out(done_out), .err_out(err_out),
    .misaligned_out(misaligned_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".haddr"},  haddr_out,   32'h0);
    chk({tag, ".htrans"}, htrans_out,  32'h0);
    chk({tag, ".hwrite"}, hwrite_out,  32'h0);
    chk({tag, ".hsize"},  hsize_out,   32'h0);
    chk({tag, ".hwdata"}, hwdata_out,  32'h0);
    chk({tag, ".mask"},   wr_mask_out, 32'h0);
    chk({tag, ".done"},   done_out,    32'h0);
    chk({tag, ".err"},    err_out,     32'h0);
    chk({tag, ".mis"},    misaligned_out, 32'h0);
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] ea, input logic [2:0] es);
    chk({tag, ".htrans"}, htrans_out,  32'h2);
    chk({tag, ".hwrite"}, hwrite_out,  32'h1);
    chk({tag, ".haddr"},  haddr_out,   ea);
    chk({tag, ".hsize"},  hsize_out,   32'(es));
    chk({tag, ".hwdata"}, hwdata_out,  32'h0);
    chk({tag, ".mask"},   wr_mask_out, 32'h0);
    chk({tag, ".stall"},  stall_out,   32'h1);
  endtask

  task automatic chk_data(input string tag, input logic [31:0] ed, input logic [3:0] em);
    chk({tag, ".htrans"}, htrans_out,  32'h0);
    chk({tag, ".hwrite"}, hwrite_out,  32'h0);
    chk({tag, ".hwdata"}, hwdata_out,  ed);
    chk({tag, ".mask"},   wr_mask_out, 32'(em));
    chk({tag, ".stall"},  stall_out,   32'h1);
    chk({tag, ".done"},   done_out,    32'h0);
  endtask

  // Full zero-wait transfer; starts and ends one time unit after a rising edge
  task automatic run_xfer(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] ea, input logic [2:0] es,
                          input logic [31:0] ed, input logic [3:0] em, input logic eerr);
    st_req_in = 1'b1; st_size_in = sz; iadder_in = addr; rs2_in = data;
    ahb_ready_in = 1'b1;
    #1;
    chk({tag, ".c0.stall"}, stall_out, 32'h1);
    tick();
    st_req_in = 1'b0;
    chk_addr({tag, ".c1"}, ea, es);
    tick();
    chk_data({tag, ".c2"}, ed, em);
    tick();
    chk({tag, ".c3.done"},   done_out,    32'h1);
    chk({tag, ".c3.err"},    err_out,     32'(eerr));
    chk({tag, ".c3.stall"},  stall_out,   32'h0);
    chk({tag, ".c3.htrans"}, htrans_out,  32'h0);
    chk({tag, ".c3.haddr"},  haddr_out,   32'h0);
    chk({tag, ".c3.hwdata"}, hwdata_out,  32'h0);
    chk({tag, ".c3.mask"},   wr_mask_out, 32'h0);
    tick();
    chk({tag, ".c4.done"}, done_out, 32'h0);
    chk({tag, ".c4.err"},  err_out,  32'h0);
  endtask

  initial begin
    rst_in = 1'b1; st_req_in = 1'b0; st_size_in = 2'b00; iadder_in = '0;
    rs2_in = '0; ahb_ready_in = 1'b1; ahb_resp_in = 1'b0;
    tick(); tick();
    chk_quiet("rst");
    chk("rst.stall", stall_out, 32'h0);
    rst_in = 1'b0;
    tick();

    // Byte store at lane 3
    run_xfer("byte3", 2'b00, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 3'b000,
             32'hA5A5_A5A5, 4'b1000, 1'b0);
    // Byte store at lane 1
    run_xfer("byte1", 2'b00, 32'h0000_1101, 32'h0000_003C, 32'h0000_1100, 3'b000,
             32'h3C3C_3C3C, 4'b0010, 1'b0);

    // Half store with two wait states in the address phase
    st_req_in = 1'b1; st_size_in = 2'b01; iadder_in = 32'h0000_2002;
    rs2_in = 32'h1234_BEEF; ahb_ready_in = 1'b0;
    tick();
    st_req_in = 1'b0;
    chk_addr("half.c1", 32'h0000_2000, 3'b001);
    tick();
    chk_addr("half.c2", 32'h0000_2000, 3'b001);
    tick();
    ahb_ready_in = 1'b1;
    chk_addr("half.c3", 32'h0000_2000, 3'b001);
    tick();
    chk_data("half.c4", 32'hBEEF_BEEF, 4'b1100);
    tick();
    chk("half.c5.done", done_out, 32'h1);
    chk("half.c5.stall", stall_out, 32'h0);
    tick();
    chk("half.c6.done", done_out, 32'h0);

    // Half store low lanes
    run_xfer("half0", 2'b01, 32'h0000_2100, 32'hFFFF_5A6B, 32'h0000_2100, 3'b001,
             32'h5A6B_5A6B, 4'b0011, 1'b0);

    // Misaligned word store: pulse only, no transfer, no stall
    st_req_in = 1'b1; st_size_in = 2'b10; iadder_in = 32'h0000_3001;
    rs2_in = 32'hCAFE_F00D;
    #1;
    chk("mis.c0.stall", stall_out, 32'h0);
    tick();
    st_req_in = 1'b0;
    chk("mis.c1.mis",    misaligned_out, 32'h1);
    chk("mis.c1.htrans", htrans_out,     32'h0);
    chk("mis.c1.stall",  stall_out,      32'h0);
    tick();
    chk("mis.c2.mis",    misaligned_out, 32'h0);
    chk("mis.c2.htrans", htrans_out,     32'h0);

    // Misaligned half store
    st_req_in = 1'b1; st_size_in = 2'b01; iadder_in = 32'h0000_3003;
    tick();
    st_req_in = 1'b0;
    chk("mish.c1.mis",    misaligned_out, 32'h1);
    chk("mish.c1.htrans", htrans_out,     32'h0);
    tick();

    // Aligned word retry, and size 11 treated as word
    run_xfer("word", 2'b10, 32'h0000_3000, 32'hCAFE_F00D, 32'h0000_3000, 3'b010,
             32'hCAFE_F00D, 4'b1111, 1'b0);
    run_xfer("size3", 2'b11, 32'h0000_3204, 32'h0BAD_BEEF, 32'h0000_3204, 3'b010,
             32'h0BAD_BEEF, 4'b1111, 1'b0);

    // Bus error on the data phase
    ahb_resp_in = 1'b1;
    run_xfer("err", 2'b10, 32'h0000_4000, 32'h1111_2222, 32'h0000_4000, 3'b010,
             32'h1111_2222, 4'b1111, 1'b1);
    ahb_resp_in = 1'b0;

    // Reset asserted during a stalled data phase
    st_req_in = 1'b1; st_size_in = 2'b10; iadder_in = 32'h0000_5000;
    rs2_in = 32'h5555_AAAA; ahb_ready_in = 1'b1;
    tick();
    st_req_in = 1'b0;
    tick();
    ahb_ready_in = 1'b0;
    chk_data("rstd.c2", 32'h5555_AAAA, 4'b1111);
    tick();
    chk_data("rstd.c3", 32'h5555_AAAA, 4'b1111);
    #2;
    rst_in = 1'b1;
    #1;
    chk_quiet("rstd.async");
    chk("rstd.async.stall", stall_out, 32'h0);
    tick();
    rst_in = 1'b0; ahb_ready_in = 1'b1;
    chk_quiet("rstd.held");
    tick();
    chk("rstd.after.done", done_out, 32'h0);
    chk("rstd.after.stall", stall_out, 32'h0);
    run_xfer("postrst", 2'b00, 32'h0000_5002, 32'h0000_0077, 32'h0000_5000, 3'b000,
             32'h7777_7777, 4'b0100, 1'b0);

    // Request held high: second transfer only after done
    st_req_in = 1'b1; st_size_in = 2'b10; iadder_in = 32'h0000_6000;
    rs2_in = 32'h6666_6666;
    tick();
    chk_addr("hold.c1", 32'h0000_6000, 3'b010);
    tick();
    chk_data("hold.c2", 32'h6666_6666, 4'b1111);
    tick();
    chk("hold.c3.done",   done_out,   32'h1);
    chk("hold.c3.htrans", htrans_out, 32'h0);
    chk("hold.c3.stall",  stall_out,  32'h1);
    tick();
    st_req_in = 1'b0;
    chk_addr("hold.c4", 32'h0000_6000, 3'b010);
    chk("hold.c4.done", done_out, 32'h0);
    tick();
    chk_data("hold.c5", 32'h6666_6666, 4'b1111);
    tick();
    chk("hold.c6.done", done_out, 32'h1);
    tick();
    chk("hold.c7.htrans", htrans_out, 32'h0);
    chk("hold.c7.stall",  stall_out,  32'h0);
    chk("hold.c7.done",   done_out,   32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
